// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped BTB next-PC predictor with 2-bit counters
// Optional hit/redirect statistics counters enabled by defining BTB_STATS_EN.
module branch_target_buffer #(
  parameter int ENTRIES = 16,
  localparam int IDX_W  = $clog2(ENTRIES),
  localparam int TAG_W  = 32 - 2 - IDX_W
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i,
`ifdef BTB_STATS_EN
  output logic [31:0] lookup_hit_cnt_o,
  output logic [31:0] redirect_cnt_o,
`endif
  output logic [31:0] next_pc_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o
);

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] ptag;
  logic             hit;
  logic [31:0]      pc_plus4;

  logic [IDX_W-1:0] uidx;
  logic [TAG_W-1:0] utag;
  logic             uhit;

  // Byte-offset bits of both PCs carry no information for word-aligned fetch.
  logic unused_bits;
  assign unused_bits = ^{pc_i[1:0], upd_pc_i[1:0]};

  always_comb begin
    idx      = pc_i[IDX_W+1:2];
    ptag     = pc_i[31:IDX_W+2];
    hit      = valid_q[idx] && (tag_q[idx] == ptag);
    pc_plus4 = {pc_i[31:2] + 30'd1, 2'b00};

    pred_taken_o  = hit && ctr_q[idx][1];
    pred_target_o = hit ? target_q[idx] : 32'd0;

    if (redirect_i)
      next_pc_o = redirect_pc_i;
    else if (pred_taken_o)
      next_pc_o = target_q[idx];
    else
      next_pc_o = pc_plus4;
  end

  always_comb begin
    uidx = upd_pc_i[IDX_W+1:2];
    utag = upd_pc_i[31:IDX_W+2];
    uhit = valid_q[uidx] && (tag_q[uidx] == utag);
  end

  // Lookup reads the arrays combinationally, so a same-cycle update to the
  // same index only becomes visible after this edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (start_i && upd_valid_i) begin
      if (uhit) begin
        if (upd_taken_i) begin
          if (ctr_q[uidx] != 2'b11)
            ctr_q[uidx] <= ctr_q[uidx] + 2'b01;
          target_q[uidx] <= upd_target_i;
        end else if (ctr_q[uidx] != 2'b00) begin
          ctr_q[uidx] <= ctr_q[uidx] - 2'b01;
        end
      end else if (upd_taken_i) begin
        valid_q[uidx]  <= 1'b1;
        tag_q[uidx]    <= utag;
        target_q[uidx] <= upd_target_i;
        ctr_q[uidx]    <= 2'b10;
      end
    end
  end

`ifdef BTB_STATS_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lookup_hit_cnt_o <= 32'd0;
      redirect_cnt_o   <= 32'd0;
    end else if (start_i) begin
      if (hit)
        lookup_hit_cnt_o <= lookup_hit_cnt_o + 32'd1;
      if (redirect_i)
        redirect_cnt_o <= redirect_cnt_o + 32'd1;
    end
  end
`endif

endmodule
